clken_multi: RTL and testbench
==============================

Name: clken_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-rate clock-enable divider.
- Generates NUM_CH independent single-cycle enable pulses from one system clock; each channel's divide ratio is programmed at run time.
- Each channel runs periodic or one-shot.
- Feeds display refresh, debounce and animation logic that need several slow enables from the 50 MHz clock.

Parameters:
NUM_CH, 4, number of independent tick channels (1..16)
DIV_W, 32, width of each channel's divide value and counter
CH_W, 2, width of channel select (ceil(log2(NUM_CH)), minimum 1)
DEF_DIV, 10000000, divide value each channel holds after reset (channel stopped)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  config write strobe, sampled on clk rising edge
cfg_ch  input  CH_W  channel addressed by cfg_we
cfg_div  input  DIV_W  divide value D for addressed channel
cfg_run  input  1  1 = start channel, 0 = stop channel
cfg_oneshot  input  1  1 = stop automatically after first tick
sync  input  1  single-cycle pulse: re-phase all running channels
hold  input  1  level: freeze all counters, suppress ticks
tick  output  NUM_CH  per-channel enable pulse, one cycle wide, registered
running  output  NUM_CH  per-channel run status, registered

Behaviour:
- Reset (async, any time, mid-count included): every cnt=0, div=DEF_DIV, run=0, oneshot=0, tick=0, running=0. First edge after deassertion starts from this state.
- Per channel i: registers div[i], cnt[i] (DIV_W bits), run[i], oneshot[i]. running[i] mirrors run[i].
- Counting (run[i]=1, hold=0, div[i]>=1):
  - cnt[i] < div[i]-1: cnt increments and tick[i]=0 next cycle.
  - cnt[i] == div[i]-1: cnt wraps to 0 and tick[i]=1 next cycle.
  - Result: tick period is exactly D cycles; D=1 holds tick high every cycle.
- Latency: after a cfg_we start on edge E, cnt=0 and tick=0. The first tick is high in the cycle after edge E+D, then every D cycles.
- div[i]==0 with cfg_run=1: channel treated as stopped; run[i] forced to 0 and no tick.
- Config write (cfg_we=1, cfg_ch<NUM_CH):
  - Loads div/oneshot from the inputs and sets run=cfg_run.
  - Clears cnt and forces tick=0 for that channel on the same edge.
  - Other channels are unaffected.
- cfg_ch >= NUM_CH: write ignored entirely.
- One-shot: on the edge that produces the tick, run[i] clears. tick[i] is high for exactly one cycle, then the channel is idle until rewritten.
- Stopped channel (run=0): cnt holds at 0, tick=0.
- sync=1: every running channel not addressed by a simultaneous cfg_we clears cnt to 0 and drives tick=0. The next tick follows D cycles after that edge.
- hold=1: cnt, run and oneshot freeze and tick=0.
  - cfg_we is still accepted under hold.
  - sync is still accepted under hold.
  - Counting resumes from the frozen value when hold drops.
- Simultaneous events on one channel, priority: reset > cfg_we > sync > hold > terminal count. A cfg_we on the terminal-count edge suppresses that tick.
- Arithmetic: unsigned DIV_W; cnt never exceeds div-1. If a write lowers div below the current count, the write clears cnt, so this cannot happen.

Optional Feature:
- Macro: CLKEN_MULTI_LEVEL_EN.
- When defined:
  - Adds output port level (NUM_CH), reset to 0.
  - level[i] toggles on every cycle in which tick[i] is high, giving a 50% square wave of period 2*D cycles.
  - level[i] is cleared by a cfg_we to channel i and by reset. It is not cleared by sync or hold.
- When undefined: the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then cfg_we ch0 D=5 run=1 oneshot=0 → tick[0] high in cycle 5 after the write edge, then cycles 10, 15; running[0]=1; other ticks stay 0.
- ch1 D=3 oneshot=1 → single tick[1] at cycle 3; running[1] falls on the same edge; no further ticks over 50 cycles.
- ch0 D=4 and ch2 D=4 started 2 cycles apart; pulse sync → both tick together 4 cycles after sync, thereafter in phase.
- ch0 D=6 running; hold high cycles 3–7 → no ticks during hold; tick occurs 3 cycles after hold drops.
- Write D=0 run=1, and write to cfg_ch=NUM_CH (when NUM_CH is not a power of 2) → channel stays stopped; out-of-range write changes nothing.
- ch3 D=2 running; assert reset mid-count for 1 cycle → tick/running all 0 immediately (asynchronous); no tick until rewritten. With CLKEN_MULTI_LEVEL_EN: level[3] toggles every 2 cycles before reset and reads 0 after.

Source files
------------

// File: rtl/clken_multi.sv
// Multi-channel programmable clock-enable generator: NUM_CH independent periodic/one-shot ticks.
// Optional square-wave level output per channel when CLKEN_MULTI_LEVEL_EN is defined.
module clken_multi #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned DEF_DIV = 10000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_run,
  input  logic              cfg_oneshot,
  input  logic              sync,
  input  logic              hold,
  output logic [NUM_CH-1:0] tick,
`ifdef CLKEN_MULTI_LEVEL_EN
  output logic [NUM_CH-1:0] level,
`endif
  output logic [NUM_CH-1:0] running
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             os_q, os_d;
    logic             tick_q, tick_d;
    logic             wr;
    logic             term;

    // Out-of-range channel numbers never match any g, so such writes fall through.
    assign wr   = cfg_we && (cfg_ch == CH_W'(g));
    assign term = (cnt_q == div_q - DIV_W'(1));

    always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      os_d   = os_q;
      tick_d = 1'b0;
      if (wr) begin
        div_d = cfg_div;
        os_d  = cfg_oneshot;
        // A zero divide value can never tick, so it is treated as a stop.
        run_d = cfg_run && (cfg_div != '0);
        cnt_d = '0;
      end else if (run_q && (div_q != '0)) begin
        if (sync) begin
          cnt_d = '0;
        end else if (!hold) begin
          if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (os_q) run_d = 1'b0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
      end else if (!hold) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        div_q  <= DIV_W'(DEF_DIV);
        cnt_q  <= '0;
        run_q  <= 1'b0;
        os_q   <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        run_q  <= run_d;
        os_q   <= os_d;
        tick_q <= tick_d;
      end
    end

    assign tick[g]    = tick_q;
    assign running[g] = run_q;

`ifdef CLKEN_MULTI_LEVEL_EN
    logic level_q, level_d;

    // Toggle in each cycle where tick is high: half-period of D cycles.
    always_comb begin
      level_d = level_q ^ tick_q;
      if (wr) level_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level_d;
    end

    assign level[g] = level_q;
`endif
  end

endmodule

// File: tb/tb_clken_multi.sv
// Self-checking bench for clken_multi: directed scenarios then random traffic, checked against a
// timestamp-based model (each channel predicts the absolute edge of its next tick).
module tb_clken_multi;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned DIV_W   = 32;
  localparam int unsigned CH_W    = 3;  // one spare bit so out-of-range channels can be addressed
  localparam int unsigned DEF_DIV = 10000000;

  logic              clk;
  logic              reset;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_run;
  logic              cfg_oneshot;
  logic              sync;
  logic              hold;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] running;
`ifdef CLKEN_MULTI_LEVEL_EN
  logic [NUM_CH-1:0] level;
`endif

  clken_multi #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W),
    .CH_W   (CH_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_run    (cfg_run),
    .cfg_oneshot(cfg_oneshot),
    .sync       (sync),
    .hold       (hold),
    .tick       (tick),
`ifdef CLKEN_MULTI_LEVEL_EN
    .level      (level),
`endif
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model state: absolute edge index at which each running channel will next tick.
  longint      now;
  longint      m_next [NUM_CH];
  int unsigned m_div  [NUM_CH];
  bit [NUM_CH-1:0] m_run, m_os, m_tick, m_level;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]  = DEF_DIV;
      m_next[i] = 0;
    end
    m_run = '0; m_os = '0; m_tick = '0; m_level = '0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && cfg_ch == CH_W'(i)) begin
        m_div[i]   = cfg_div;
        m_os[i]    = cfg_oneshot;
        m_run[i]   = cfg_run && (cfg_div != 0);
        m_next[i]  = now + longint'(cfg_div);
        m_tick[i]  = 1'b0;
        m_level[i] = 1'b0;
      end else begin
        if (m_tick[i]) m_level[i] = ~m_level[i];
        m_tick[i] = 1'b0;
        if (m_run[i]) begin
          if (sync) m_next[i] = now + longint'(m_div[i]);
          else if (hold) m_next[i] = m_next[i] + 1;
          else if (now == m_next[i]) begin
            m_tick[i] = 1'b1;
            m_next[i] = m_next[i] + longint'(m_div[i]);
            if (m_os[i]) m_run[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("running", 32'(running), 32'(m_run));
`ifdef CLKEN_MULTI_LEVEL_EN
    chk("level", 32'(level), 32'(m_level));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    now++;
    #1;
    compare_all();
  endtask

  task automatic wr(input int ch, input int d, input bit r, input bit os);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(d); cfg_run = r; cfg_oneshot = os;
    step();
    cfg_we = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; pulses reset between edges.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
`ifdef CLKEN_MULTI_LEVEL_EN
    chk("reset_level", 32'(level), 32'd0);
`endif
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_run = 1'b0;
    cfg_oneshot = 1'b0; sync = 1'b0; hold = 1'b0;
    now = 0;
    model_reset();
    #12;
    chk("init_tick", 32'(tick), 32'd0);
    chk("init_running", 32'(running), 32'd0);
    reset = 1'b0;
    step();

    // Periodic D=5 on ch0: ticks 5, 10, 15 edges after the write.
    wr(0, 5, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k % 5 == 0) chk("ch0_period5", 32'(tick[0]), 32'd1);
    end
    wr(0, 0, 1'b0, 1'b0);

    // One-shot D=3 on ch1, then a long quiet window.
    wr(1, 3, 1'b1, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 3) chk("ch1_oneshot", 32'(tick[1]), 32'd1);
    end

    // Two channels out of phase, then re-phased by sync.
    wr(0, 4, 1'b1, 1'b0);
    step(); step();
    wr(2, 4, 1'b1, 1'b0);
    step(); step(); step();
    sync = 1'b1; step(); sync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("sync_phase", 32'(tick[0]), 32'(tick[2]));
    end
    wr(2, 0, 1'b0, 1'b0);

    // Hold freezes ch0 mid-count.
    wr(0, 6, 1'b1, 1'b0);
    step(); step();
    hold = 1'b1;
    for (int k = 0; k < 5; k++) step();
    hold = 1'b0;
    for (int k = 0; k < 10; k++) step();
    wr(0, 0, 1'b0, 1'b0);

    // Zero divide and out-of-range channel writes.
    wr(1, 0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step();
    wr(NUM_CH + 1, 3, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step();

    // Asynchronous reset mid-count on ch3.
    wr(3, 2, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step();
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_reset_ch3", 32'(tick[3]), 32'd0);
    end

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_ch      = CH_W'($urandom_range(0, 7));
      cfg_div     = DIV_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6));
      cfg_run     = ($urandom_range(0, 4) != 0);
      cfg_oneshot = ($urandom_range(0, 3) == 0);
      sync        = ($urandom_range(0, 15) == 0);
      hold        = ($urandom_range(0, 5) == 0);
      step();
    end
    cfg_we = 1'b0; sync = 1'b0; hold = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
